// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C transaction sequencer and its neighbours:
//   cmd_t          - byte-engine command encodings
//   mode_t         - instruction mode encodings (only i2c_mode[2:0] is decoded)
//   vi_t           - valid_instr codes presented by the arbiter
//   I2C_DEV_ADDR   - default 7-bit bus address of the temperature sensor
//   mode_is_legal  - helper telling whether a 3-bit mode is a supported operation
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_START     = 3'd1,
        CMD_STOP      = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_READ_ACK  = 3'd4,
        CMD_READ_NACK = 3'd5
    } cmd_t;

    typedef enum logic [2:0] {
        MODE_PTR = 3'b000,
        MODE_RD2 = 3'b001,
        MODE_RD1 = 3'b010,
        MODE_WR1 = 3'b011,
        MODE_WR2 = 3'b100
    } mode_t;

    typedef enum logic [1:0] {
        VI_NONE    = 2'b00,
        VI_QUEUED  = 2'b01,
        VI_DEFAULT = 2'b11
    } vi_t;

    localparam logic [6:0] I2C_DEV_ADDR = 7'h48;

    // Modes 101..111 are illegal and produce an immediate error completion.
    function automatic logic mode_is_legal(input logic [2:0] mode);
        return (mode <= 3'd4);
    endfunction

endpackage

// File: rtl/i2c_txn_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_txn_sequencer
// Turns one arbiter instruction into a sequence of byte-engine commands
// (START, device/pointer/data writes, repeated START, reads, STOP), assembles
// read bytes into a 16-bit result and reports NACK failures.
//
// Optional feature macro: I2C_RETRY_EN
//   defined   - a NACKed transaction is retried (full START..STOP) up to
//               MAX_RETRY times before err_nack is reported.
//   undefined - the first NACK ends the transaction with err_nack.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   valid_instr[1:0]    00 none, 01 queued, 11 default read (sampled in ARM)
//   i2c_mode[7:0]       operation, [2:0] decoded
//   i2c_address[7:0]    sensor register pointer
//   i2c_data[15:0]      write data, high byte first
//   i2c_ready           one-cycle request pulse to the arbiter
//   cmd_valid/cmd/cmd_byte, cmd_ready   command channel to the byte engine
//   rsp_valid/rsp_byte/rsp_nack         response channel from the byte engine
//   rd_data[15:0]       last successful read result
//   txn_done            one-cycle completion pulse
//   txn_default         qualifies txn_done: finished instruction was a default read
//   err_nack            one-cycle pulse with txn_done on failure
// All outputs are driven directly from flops.
// -----------------------------------------------------------------------------
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR
`ifdef I2C_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY = 32'd3
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  valid_instr,
    input  logic [7:0]  i2c_mode,
    input  logic [7:0]  i2c_address,
    input  logic [15:0] i2c_data,
    output logic        i2c_ready,
    output logic        cmd_valid,
    output logic [2:0]  cmd,
    output logic [7:0]  cmd_byte,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_byte,
    input  logic        rsp_nack,
    output logic [15:0] rd_data,
    output logic        txn_done,
    output logic        txn_default,
    output logic        err_nack
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ARM    = 4'd1,
        START  = 4'd2,
        DEVW   = 4'd3,
        PTR    = 4'd4,
        WRH    = 4'd5,
        WRL    = 4'd6,
        RSTART = 4'd7,
        DEVR   = 4'd8,
        RDH    = 4'd9,
        RDL    = 4'd10,
        STOP   = 4'd11,
        DONE   = 4'd12
    } state_t;

`ifdef I2C_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 32'd1) ? 1 : $clog2(MAX_RETRY + 32'd1);
    logic [RETRY_W-1:0] retry_q, retry_d;
`endif

    state_t      state_q, state_d;
    logic        wait_q, wait_d;          // command accepted, response outstanding
    logic        fail_q, fail_d;          // a NACK (or illegal mode) ended this attempt
    logic [2:0]  mode_q, mode_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        dflt_q, dflt_d;
    logic [7:0]  rd_hi_q, rd_hi_d;
    logic [7:0]  rd_lo_q, rd_lo_d;
    logic        ready_q, ready_d;
    logic        cmd_valid_q, cmd_valid_d;
    cmd_t        cmd_q, cmd_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic        default_q, default_d;
    logic        err_q, err_d;
    logic        launch_s;                // issue the command belonging to state_d
    logic        unused_s;

    // Only the low three mode bits carry meaning.
    assign unused_s = ^i2c_mode[7:3];

    // State, instruction latches and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_q      <= 1'b0;
            fail_q      <= 1'b0;
            mode_q      <= 3'd0;
            addr_q      <= 8'd0;
            data_q      <= 16'd0;
            dflt_q      <= 1'b0;
            rd_hi_q     <= 8'd0;
            rd_lo_q     <= 8'd0;
            ready_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            cmd_byte_q  <= 8'd0;
            rd_data_q   <= 16'd0;
            done_q      <= 1'b0;
            default_q   <= 1'b0;
            err_q       <= 1'b0;
`ifdef I2C_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            fail_q      <= fail_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            dflt_q      <= dflt_d;
            rd_hi_q     <= rd_hi_d;
            rd_lo_q     <= rd_lo_d;
            ready_q     <= ready_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            cmd_byte_q  <= cmd_byte_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            default_q   <= default_d;
            err_q       <= err_d;
`ifdef I2C_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // Next-state, command handshake and output-register inputs.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        fail_d      = fail_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        data_d      = data_q;
        dflt_d      = dflt_q;
        rd_hi_d     = rd_hi_q;
        rd_lo_d     = rd_lo_q;
        ready_d     = 1'b0;
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        cmd_byte_d  = cmd_byte_q;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        default_d   = 1'b0;
        err_d       = 1'b0;
        launch_s    = 1'b0;
`ifdef I2C_RETRY_EN
        retry_d     = retry_q;
`endif

        case (state_q)
            // The first IDLE cycle only arms the pulse, so every entry to IDLE
            // (reset release included) yields exactly one i2c_ready cycle.
            IDLE: begin
                if (!ready_q) begin
                    ready_d = 1'b1;
                end else begin
                    state_d = ARM;
                end
            end

            ARM: begin
                if (valid_instr != VI_NONE) begin
                    mode_d = i2c_mode[2:0];
                    addr_d = i2c_address;
                    data_d = i2c_data;
                    dflt_d = (valid_instr == VI_DEFAULT);
                    if (mode_is_legal(i2c_mode[2:0])) begin
                        state_d  = START;
                        launch_s = 1'b1;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            START, DEVW, PTR, WRH, WRL, RSTART, DEVR, RDH, RDL, STOP: begin
                if (cmd_valid_q) begin
                    if (cmd_ready) begin
                        cmd_valid_d = 1'b0;
                        wait_d      = 1'b1;
                    end else begin
                        cmd_valid_d = 1'b1;
                    end
                end else if (wait_q && rsp_valid) begin
                    wait_d   = 1'b0;
                    launch_s = 1'b1;
                    case (state_q)
                        START:  state_d = DEVW;
                        RSTART: state_d = DEVR;
                        DEVW: begin
                            if (rsp_nack) begin
                                fail_d  = 1'b1;
                                state_d = STOP;
                            end else begin
                                state_d = PTR;
                            end
                        end
                        PTR: begin
                            if (rsp_nack) begin
                                fail_d  = 1'b1;
                                state_d = STOP;
                            end else begin
                                case (mode_q)
                                    MODE_PTR: state_d = STOP;
                                    MODE_WR1: state_d = WRL;
                                    MODE_WR2: state_d = WRH;
                                    default:  state_d = RSTART;
                                endcase
                            end
                        end
                        WRH: begin
                            if (rsp_nack) begin
                                fail_d  = 1'b1;
                                state_d = STOP;
                            end else begin
                                state_d = WRL;
                            end
                        end
                        WRL: begin
                            if (rsp_nack) begin
                                fail_d = 1'b1;
                            end else begin
                                fail_d = fail_q;
                            end
                            state_d = STOP;
                        end
                        DEVR: begin
                            if (rsp_nack) begin
                                fail_d  = 1'b1;
                                state_d = STOP;
                            end else begin
                                state_d = RDH;
                            end
                        end
                        RDH: begin
                            rd_hi_d = rsp_byte;
                            if (mode_q == MODE_RD1) begin
                                state_d = STOP;
                            end else begin
                                state_d = RDL;
                            end
                        end
                        RDL: begin
                            rd_lo_d = rsp_byte;
                            state_d = STOP;
                        end
                        STOP: begin
`ifdef I2C_RETRY_EN
                            if (fail_q && (retry_q < RETRY_W'(MAX_RETRY))) begin
                                retry_d = retry_q + RETRY_W'(1);
                                fail_d  = 1'b0;
                                state_d = START;
                            end else begin
                                launch_s = 1'b0;
                                state_d  = DONE;
                            end
`else
                            launch_s = 1'b0;
                            state_d  = DONE;
`endif
                        end
                        default: begin
                            launch_s = 1'b0;
                            state_d  = IDLE;
                        end
                    endcase
                end else begin
                    // Stray responses with nothing outstanding are dropped.
                    wait_d = wait_q;
                end
            end

            DONE: begin
                done_d    = 1'b1;
                default_d = dflt_q;
                err_d     = fail_q;
                if (!fail_q && (mode_q == MODE_RD2)) begin
                    rd_data_d = {rd_hi_q, rd_lo_q};
                end else if (!fail_q && (mode_q == MODE_RD1)) begin
                    rd_data_d = {rd_hi_q, 8'h00};
                end else begin
                    rd_data_d = rd_data_q;
                end
                fail_d  = 1'b0;
`ifdef I2C_RETRY_EN
                retry_d = '0;
`endif
                state_d = IDLE;
            end

            default: begin
                state_d     = IDLE;
                wait_d      = 1'b0;
                fail_d      = 1'b0;
                cmd_valid_d = 1'b0;
            end
        endcase

        // Load the command for the state being entered; it is then held
        // unchanged until the engine accepts it.
        if (launch_s) begin
            cmd_valid_d = 1'b1;
            case (state_d)
                START, RSTART: begin
                    cmd_d      = CMD_START;
                    cmd_byte_d = 8'h00;
                end
                STOP: begin
                    cmd_d      = CMD_STOP;
                    cmd_byte_d = 8'h00;
                end
                DEVW: begin
                    cmd_d      = CMD_WRITE;
                    cmd_byte_d = {DEV_ADDR, 1'b0};
                end
                DEVR: begin
                    cmd_d      = CMD_WRITE;
                    cmd_byte_d = {DEV_ADDR, 1'b1};
                end
                PTR: begin
                    cmd_d      = CMD_WRITE;
                    cmd_byte_d = addr_q;
                end
                WRH: begin
                    cmd_d      = CMD_WRITE;
                    cmd_byte_d = data_q[15:8];
                end
                WRL: begin
                    cmd_d      = CMD_WRITE;
                    cmd_byte_d = data_q[7:0];
                end
                RDH: begin
                    // A single-byte read ends on its first byte.
                    cmd_d      = (mode_q == MODE_RD1) ? CMD_READ_NACK : CMD_READ_ACK;
                    cmd_byte_d = 8'h00;
                end
                RDL: begin
                    cmd_d      = CMD_READ_NACK;
                    cmd_byte_d = 8'h00;
                end
                default: begin
                    cmd_valid_d = 1'b0;
                end
            endcase
        end else begin
            cmd_valid_d = cmd_valid_d;
        end
    end

    assign i2c_ready   = ready_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd         = cmd_q;
    assign cmd_byte    = cmd_byte_q;
    assign rd_data     = rd_data_q;
    assign txn_done    = done_q;
    assign txn_default = default_q;
    assign err_nack    = err_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer: the bench plays both the arbiter and
// the byte engine, driving on the falling edge and sampling there as well.
module tb_i2c_txn_sequencer;
    import i2c_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  valid_instr;
    logic [7:0]  i2c_mode;
    logic [7:0]  i2c_address;
    logic [15:0] i2c_data;
    logic        i2c_ready;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [7:0]  cmd_byte;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_byte;
    logic        rsp_nack;
    logic [15:0] rd_data;
    logic        txn_done;
    logic        txn_default;
    logic        err_nack;

    int n_checks = 0;
    int n_errors = 0;

    i2c_txn_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .valid_instr (valid_instr),
        .i2c_mode    (i2c_mode),
        .i2c_address (i2c_address),
        .i2c_data    (i2c_data),
        .i2c_ready   (i2c_ready),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_byte    (cmd_byte),
        .cmd_ready   (cmd_ready),
        .rsp_valid   (rsp_valid),
        .rsp_byte    (rsp_byte),
        .rsp_nack    (rsp_nack),
        .rd_data     (rd_data),
        .txn_done    (txn_done),
        .txn_default (txn_default),
        .err_nack    (err_nack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present an instruction when i2c_ready is seen; checks the N / N+1 / N+2 timing.
    task automatic start_instr(input string tag, input logic [1:0] vi, input logic [7:0] md,
                               input logic [7:0] ad, input logic [15:0] dt, input logic exp_start);
        check_eq({tag, "_ready"}, {31'd0, i2c_ready}, 32'd1);
        valid_instr = vi;
        i2c_mode    = md;
        i2c_address = ad;
        i2c_data    = dt;
        @(negedge clk);
        check_eq({tag, "_ready_lo"}, {31'd0, i2c_ready}, 32'd0);
        @(negedge clk);
        valid_instr = 2'b00;
        check_eq({tag, "_start_vld"}, {31'd0, cmd_valid}, {31'd0, exp_start});
    endtask

    // Expect one command already valid, accept it, then answer it.
    task automatic do_cmd(input string tag, input logic [2:0] ec, input logic [7:0] eb,
                          input logic nack, input logic [7:0] rb);
        check_eq({tag, "_vld"}, {31'd0, cmd_valid}, 32'd1);
        check_eq({tag, "_cmd"}, {29'd0, cmd}, {29'd0, ec});
        check_eq({tag, "_byte"}, {24'd0, cmd_byte}, {24'd0, eb});
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check_eq({tag, "_accepted"}, {31'd0, cmd_valid}, 32'd0);
        rsp_valid = 1'b1;
        rsp_byte  = rb;
        rsp_nack  = nack;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        rsp_byte  = 8'h00;
    endtask

    // Called in the DONE cycle: completion pulse next cycle, ready the one after.
    task automatic finish_txn(input string tag, input logic exp_dflt, input logic exp_err,
                              input logic [15:0] exp_rd);
        @(negedge clk);
        check_eq({tag, "_done"}, {31'd0, txn_done}, 32'd1);
        check_eq({tag, "_default"}, {31'd0, txn_default}, {31'd0, exp_dflt});
        check_eq({tag, "_err"}, {31'd0, err_nack}, {31'd0, exp_err});
        check_eq({tag, "_rd_data"}, {16'd0, rd_data}, {16'd0, exp_rd});
        @(negedge clk);
        check_eq({tag, "_done_lo"}, {31'd0, txn_done}, 32'd0);
        check_eq({tag, "_next_ready"}, {31'd0, i2c_ready}, 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        valid_instr = 2'b00;
        i2c_mode    = 8'h00;
        i2c_address = 8'h00;
        i2c_data    = 16'h0000;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_byte    = 8'h00;
        rsp_nack    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ready", {31'd0, i2c_ready}, 32'd0);
        check_eq("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check_eq("rst_rd_data", {16'd0, rd_data}, 32'd0);
        check_eq("rst_done", {31'd0, txn_done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Default temperature read: 0x19, 0x80 -> 0x1980
        start_instr("dflt", 2'b11, 8'h01, 8'h00, 16'h0000, 1'b1);
        do_cmd("dflt_start",  CMD_START,     8'h00, 1'b0, 8'h00);
        do_cmd("dflt_devw",   CMD_WRITE,     8'h90, 1'b0, 8'h00);
        do_cmd("dflt_ptr",    CMD_WRITE,     8'h00, 1'b0, 8'h00);
        do_cmd("dflt_rstart", CMD_START,     8'h00, 1'b0, 8'h00);
        do_cmd("dflt_devr",   CMD_WRITE,     8'h91, 1'b0, 8'h00);
        do_cmd("dflt_rdh",    CMD_READ_ACK,  8'h00, 1'b0, 8'h19);
        do_cmd("dflt_rdl",    CMD_READ_NACK, 8'h00, 1'b0, 8'h80);
        do_cmd("dflt_stop",   CMD_STOP,      8'h00, 1'b0, 8'h00);
        finish_txn("dflt", 1'b1, 1'b0, 16'h1980);

        // Write-2: rd_data holds
        start_instr("wr2", 2'b01, 8'h04, 8'h04, 16'h2A50, 1'b1);
        do_cmd("wr2_start", CMD_START, 8'h00, 1'b0, 8'h00);
        do_cmd("wr2_devw",  CMD_WRITE, 8'h90, 1'b0, 8'h00);
        do_cmd("wr2_ptr",   CMD_WRITE, 8'h04, 1'b0, 8'h00);
        do_cmd("wr2_hi",    CMD_WRITE, 8'h2A, 1'b0, 8'h00);
        do_cmd("wr2_lo",    CMD_WRITE, 8'h50, 1'b0, 8'h00);
        do_cmd("wr2_stop",  CMD_STOP,  8'h00, 1'b0, 8'h00);
        finish_txn("wr2", 1'b0, 1'b0, 16'h1980);

        // Write-1: only the low data byte goes out
        start_instr("wr1", 2'b01, 8'h03, 8'h02, 16'hBEEF, 1'b1);
        do_cmd("wr1_start", CMD_START, 8'h00, 1'b0, 8'h00);
        do_cmd("wr1_devw",  CMD_WRITE, 8'h90, 1'b0, 8'h00);
        do_cmd("wr1_ptr",   CMD_WRITE, 8'h02, 1'b0, 8'h00);
        do_cmd("wr1_lo",    CMD_WRITE, 8'hEF, 1'b0, 8'h00);
        do_cmd("wr1_stop",  CMD_STOP,  8'h00, 1'b0, 8'h00);
        finish_txn("wr1", 1'b0, 1'b0, 16'h1980);

        // Read-1: single NACKed read, low byte zeroed
        start_instr("rd1", 2'b01, 8'h02, 8'h05, 16'h0000, 1'b1);
        do_cmd("rd1_start",  CMD_START,     8'h00, 1'b0, 8'h00);
        do_cmd("rd1_devw",   CMD_WRITE,     8'h90, 1'b0, 8'h00);
        do_cmd("rd1_ptr",    CMD_WRITE,     8'h05, 1'b0, 8'h00);
        do_cmd("rd1_rstart", CMD_START,     8'h00, 1'b0, 8'h00);
        do_cmd("rd1_devr",   CMD_WRITE,     8'h91, 1'b0, 8'h00);
        do_cmd("rd1_rd",     CMD_READ_NACK, 8'h00, 1'b0, 8'h3C);
        do_cmd("rd1_stop",   CMD_STOP,      8'h00, 1'b0, 8'h00);
        finish_txn("rd1", 1'b0, 1'b0, 16'h3C00);

        // Pointer-only
        start_instr("ptr", 2'b01, 8'h00, 8'h07, 16'h0000, 1'b1);
        do_cmd("ptr_start", CMD_START, 8'h00, 1'b0, 8'h00);
        do_cmd("ptr_devw",  CMD_WRITE, 8'h90, 1'b0, 8'h00);
        do_cmd("ptr_ptr",   CMD_WRITE, 8'h07, 1'b0, 8'h00);
        do_cmd("ptr_stop",  CMD_STOP,  8'h00, 1'b0, 8'h00);
        finish_txn("ptr", 1'b0, 1'b0, 16'h3C00);

        // NACK on the pointer byte of a read: rd_data must hold
        start_instr("nack", 2'b01, 8'h01, 8'h00, 16'h0000, 1'b1);
`ifdef I2C_RETRY_EN
        for (int a = 0; a < 4; a++) begin
            do_cmd("nack_start", CMD_START, 8'h00, 1'b0, 8'h00);
            do_cmd("nack_devw",  CMD_WRITE, 8'h90, 1'b0, 8'h00);
            do_cmd("nack_ptr",   CMD_WRITE, 8'h00, 1'b1, 8'h00);
            do_cmd("nack_stop",  CMD_STOP,  8'h00, 1'b0, 8'h00);
        end
`else
        do_cmd("nack_start", CMD_START, 8'h00, 1'b0, 8'h00);
        do_cmd("nack_devw",  CMD_WRITE, 8'h90, 1'b0, 8'h00);
        do_cmd("nack_ptr",   CMD_WRITE, 8'h00, 1'b1, 8'h00);
        do_cmd("nack_stop",  CMD_STOP,  8'h00, 1'b0, 8'h00);
`endif
        finish_txn("nack", 1'b0, 1'b1, 16'h3C00);

        // Illegal mode 111: no bus command, done+err two cycles after sampling
        start_instr("illegal", 2'b01, 8'h07, 8'h00, 16'h0000, 1'b0);
        finish_txn("illegal", 1'b0, 1'b1, 16'h3C00);

        // Nothing queued: ready re-pulses after returning to IDLE
        @(negedge clk);
        check_eq("none_ready_lo1", {31'd0, i2c_ready}, 32'd0);
        @(negedge clk);
        check_eq("none_ready_lo2", {31'd0, i2c_ready}, 32'd0);
        check_eq("none_no_cmd", {31'd0, cmd_valid}, 32'd0);
        @(negedge clk);
        check_eq("none_ready_again", {31'd0, i2c_ready}, 32'd1);

        // Stalled command stays stable; a stray response is ignored
        start_instr("stall", 2'b01, 8'h01, 8'h00, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rsp_valid = (i == 2);
            @(negedge clk);
            check_eq("stall_vld", {31'd0, cmd_valid}, 32'd1);
            check_eq("stall_cmd", {29'd0, cmd}, {29'd0, CMD_START});
            check_eq("stall_byte", {24'd0, cmd_byte}, 32'd0);
        end
        rsp_valid = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check_eq("stall_accepted", {31'd0, cmd_valid}, 32'd0);

        // Reset while the response is outstanding: outputs clear at once
        #1 reset = 1'b1;
        #1;
        check_eq("arst_ready", {31'd0, i2c_ready}, 32'd0);
        check_eq("arst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check_eq("arst_cmd", {29'd0, cmd}, 32'd0);
        check_eq("arst_cmd_byte", {24'd0, cmd_byte}, 32'd0);
        check_eq("arst_rd_data", {16'd0, rd_data}, 32'd0);
        check_eq("arst_done", {31'd0, txn_done}, 32'd0);
        check_eq("arst_default", {31'd0, txn_default}, 32'd0);
        check_eq("arst_err", {31'd0, err_nack}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("arst_ready_after", {31'd0, i2c_ready}, 32'd1);
        check_eq("arst_no_cmd_after", {31'd0, cmd_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
